// File: rtl/msr_pkg.sv
// Shared encodings for the multi-mode shift register: operation codes and FSM states.
package msr_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SL   = 3'b001;
    localparam logic [2:0] OP_SR   = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // True for the ops that run a multi-cycle bit-serial sequence.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SL) || (op == OP_SR) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of a shift or rotate; also reports the bit pushed out.
module shift_step
    import msr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] cur,
    input  logic [2:0]   op,
    input  logic         sli,
    input  logic         sri,
    output logic [N-1:0] nxt,
    output logic         expelled
);

    always_comb begin
        nxt      = cur;
        expelled = 1'b0;
        case (op)
            OP_SL: begin
                nxt      = {cur[N-2:0], sli};
                expelled = cur[N-1];
            end
            OP_SR: begin
                nxt      = {sri, cur[N-1:1]};
                expelled = cur[0];
            end
            OP_SRA: begin
                nxt      = {cur[N-1], cur[N-1:1]};
                expelled = cur[0];
            end
            OP_ROL: begin
                nxt      = {cur[N-2:0], cur[N-1]};
                expelled = cur[N-1];
            end
            OP_ROR: begin
                nxt      = {cur[0], cur[N-1:1]};
                expelled = cur[0];
            end
            default: begin
                nxt      = cur;
                expelled = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_mode_shift_register.sv
// Bit-serial shift/rotate register with start/ready/busy/done handshake; one step per clock.
module multi_mode_shift_register
    import msr_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N-1:0]     in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             start,
    input  logic             sli,
    input  logic             sri,
    output logic [N-1:0]     out,
    output logic             shout,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    logic [1:0]       r_state;
    logic [N-1:0]     r_out;
    logic             r_shout;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_op;

    logic [N-1:0]     w_nxt;
    logic             w_expelled;

    shift_step #(.N(N)) u_step (
        .cur      (r_out),
        .op       (r_op),
        .sli      (sli),
        .sri      (sri),
        .nxt      (w_nxt),
        .expelled (w_expelled)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_shout <= 1'b0;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        if (op == OP_LOAD) begin
                            r_out   <= in;
                            r_state <= ST_DONE;
                        end else if (is_shift_op(op) && (amt != '0)) begin
                            r_cnt   <= amt;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_out   <= w_nxt;
                    r_shout <= w_expelled;
                    r_cnt   <= r_cnt - 1'b1;
                    // Counter holds the steps still to do, including this one.
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign shout = r_shout;
    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_multi_mode_shift_register.sv
// Randomised and directed bench for multi_mode_shift_register against an arithmetic reference model.
module tb_multi_mode_shift_register;

    localparam int N     = 8;
    localparam int AMT_W = $clog2(N + 1);

    logic             clk;
    logic             clear;
    logic [N-1:0]     in;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             start;
    logic             sli;
    logic             sri;
    logic [N-1:0]     out;
    logic             shout;
    logic             ready;
    logic             busy;
    logic             done;

    int n_cmp;
    int n_bad;

    int m_val;
    int m_shout;

    multi_mode_shift_register #(.N(N)) dut (
        .clk   (clk),
        .clear (clear),
        .in    (in),
        .op    (op),
        .amt   (amt),
        .start (start),
        .sli   (sli),
        .sri   (sri),
        .out   (out),
        .shout (shout),
        .ready (ready),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: one step of each op expressed as integer arithmetic on an N-bit value.
    task automatic model_step(input int code, input int fl, input int fr);
        int full;
        int msb;
        full = (1 << N) - 1;
        msb  = (m_val >> (N - 1)) & 1;
        case (code)
            1: begin m_shout = msb;       m_val = ((m_val * 2) + fl) & full; end
            2: begin m_shout = m_val % 2; m_val = (m_val / 2) + fr * (1 << (N - 1)); end
            3: begin m_shout = m_val % 2; m_val = (m_val / 2) + msb * (1 << (N - 1)); end
            4: begin m_shout = msb;       m_val = ((m_val * 2) + msb) & full; end
            5: begin m_shout = m_val % 2; m_val = (m_val / 2) + (m_val % 2) * (1 << (N - 1)); end
            default: ;
        endcase
    endtask

    // Runs one full transaction. rnd selects random fills, else fl/fr are held.
    // poke issues an extra start with scrambled inputs mid-sequence.
    task automatic run_op(input int code, input int count, input int din,
                          input bit rnd, input bit fl, input bit fr, input bit poke);
        int steps;
        int fill_l;
        int fill_r;
        @(negedge clk);
        check("ready_before", ready, 1);
        op    = code[2:0];
        amt   = count[AMT_W-1:0];
        in    = din[N-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        steps = (code >= 1 && code <= 5) ? count : 0;
        if (code == 6) m_val = din;
        for (int i = 0; i < steps; i++) begin
            check("busy_step", busy, 1);
            check("done_step", done, 0);
            check("out_step", out, m_val);
            fill_l = rnd ? int'($urandom_range(0, 1)) : int'(fl);
            fill_r = rnd ? int'($urandom_range(0, 1)) : int'(fr);
            sli = fill_l[0];
            sri = fill_r[0];
            if (poke && i == 1) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                amt   = AMT_W'($urandom_range(0, 15));
                in    = N'($urandom);
            end else begin
                start = 1'b0;
            end
            model_step(code, fill_l, fill_r);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("out_final", out, m_val);
        check("shout_final", shout, m_shout);
        $display("op=%0d amt=%0d in=%0h -> out=%0h shout=%0d", code, count, din, out, shout);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("ready_after", ready, 1);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_val   = 0;
        m_shout = 0;
        clear   = 1'b1;
        in      = '0;
        op      = 3'd0;
        amt     = '0;
        start   = 1'b0;
        sli     = 1'b0;
        sri     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        clear = 1'b0;

        // Clear asserted mid-shift must act immediately.
        run_op(6, 0, 'hA5, 0, 0, 0, 0);
        @(negedge clk);
        op = 3'd1; amt = AMT_W'(5); start = 1'b1; sli = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midshift_busy", busy, 1);
        clear = 1'b1;
        #1;
        check("clr_out", out, 0);
        check("clr_ready", ready, 1);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_shout", shout, 0);
        m_val = 0; m_shout = 0;
        @(negedge clk);
        clear = 1'b0;
        $display("clear mid-shift -> out=%0h shout=%0d", out, shout);

        run_op(6, 0, 'hA5, 0, 0, 0, 0);
        check("load_a5", out, 'hA5);
        run_op(2, 3, 0, 0, 0, 1, 0);
        check("sr_final", out, 'hF4);
        check("sr_shout", shout, 1);
        run_op(6, 0, 'h90, 0, 0, 0, 0);
        run_op(3, 2, 0, 0, 0, 0, 0);
        check("sra_final", out, 'hE4);
        run_op(6, 0, 'h81, 0, 0, 0, 0);
        run_op(4, 9, 0, 0, 0, 0, 1);
        check("rol_wrap", out, 'h03);
        run_op(6, 0, 'h3C, 0, 0, 0, 0);
        run_op(1, 0, 0, 0, 1, 1, 0);
        check("amt0_hold", out, 'h3C);
        run_op(7, 5, 0, 0, 1, 1, 0);
        check("rsvd_hold", out, 'h3C);
        run_op(1, 12, 0, 0, 1, 0, 0);
        check("sl_allfill", out, 'hFF);
        run_op(6, 0, 'h80, 0, 0, 0, 0);
        run_op(3, 10, 0, 0, 0, 0, 0);
        check("sra_allsign", out, 'hFF);

        for (int t = 0; t < 150; t++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)), 1, 0, 0, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
